dmem_access_ctrl: RTL and testbench
===================================

# dmem_access_ctrl

Sequential request/response controller between the MEM pipeline stage and the synchronous data SRAM (one-cycle read latency, byte write enables). It accepts one load or store at a time, checks alignment, and drives the SRAM lanes. It registers the byte offset, size and sign of loads so that alignment and extension use the data the SRAM actually returns. It then holds a registered response until the pipeline takes it.

## Interface
Parameters:
- ADDR_W, 16, SRAM word-address width; `ram_addr = req_addr[ADDR_W+1:2]`.

Ports:
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: reset, synchronous and active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller accepts a request this cycle.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: size code; 00 byte, 01 halfword, 10 word, 11 illegal.
- `req_sign` in 1: loads only; 1 = sign-extend, 0 = zero-extend.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `ram_en` out 1: SRAM enable.
- `ram_wen` out 4: SRAM byte write enables.
- `ram_addr` out ADDR_W: SRAM word index.
- `ram_wdata` out 32: SRAM write data.
- `ram_rdata` in 32: SRAM read data, valid the cycle after `ram_en` on a load.
- `resp_valid` out 1: response pending.
- `resp_ready` in 1: consumer takes the response.
- `resp_data` out 32: aligned and extended load data; 0 for stores and exceptions.
- `resp_exc` out 1: address error. Set for a misaligned access or for size 11.
- `resp_badaddr` out 32: faulting address when `resp_exc`=1, else 0.

## Operation
States: IDLE, WAIT, HOLD.

**Acceptance**
- `req_ready` = 1 only in IDLE with `resetn` = 1.
- A request is accepted when `req_valid` and `req_ready` are both 1.

**Exception check (at acceptance)**
- Exception if size = 11.
- Exception if halfword with `addr[0]` = 1.
- Exception if word with `addr[1:0]` ≠ 0.
- On exception: `ram_en` = 0; `resp_exc`=1, `resp_badaddr`=`req_addr`, `resp_data`=0 are registered; next state HOLD.

**Store (no exception)**
- `ram_en`=1 in the acceptance cycle.
- Write enables by size and offset:
  - byte: `ram_wen` = 0001 << `addr[1:0]`
  - halfword: 0011 when `addr[1]`=0, 1100 when `addr[1]`=1
  - word: 1111
- `ram_wdata` replicates lanes: byte → `{4{wdata[7:0]}}`, half → `{2{wdata[15:0]}}`, word → `wdata`.
- Register `resp_data`=0 and `resp_exc`=0; next state HOLD.

**Load (no exception)**
- `ram_en`=1 and `ram_wen`=0000 in the acceptance cycle.
- Latch `addr[1:0]`, size and sign; next state WAIT.

**WAIT**
- `ram_rdata` is valid in this cycle.
- Select the lane using the latched offset:
  - byte: `rdata[8*off+7 : 8*off]`
  - halfword: `rdata[16*off[1]+15 : 16*off[1]]`
  - word: all 32 bits
- Extend per the latched sign and register the result into `resp_data`; next state HOLD.

**HOLD**
- `resp_valid`=1.
- All `resp_*` outputs are stable until `resp_ready`=1, then IDLE.

**Outside the acceptance cycle**
- `ram_en`=0 and `ram_wen`=0.
- `ram_addr` and `ram_wdata` are don't-care; they are driven 0.

## Timing
- Reset (`resetn` low at a rising edge): state IDLE; `resp_valid`, `resp_exc`, `resp_data`, `resp_badaddr` = 0.
- While `resetn` is low: `req_ready`=0, `ram_en`=0.
- Reset in WAIT or HOLD abandons the access. No response is produced; a store already written stays written.
- Latency from acceptance cycle T:
  - store or exception: `resp_valid` at T+1
  - load: `resp_valid` at T+2
- The minimum IDLE→IDLE round trip is 2 cycles (store, with `resp_ready` held at 1) or 3 cycles (load).
- No new request is accepted in the cycle `resp_ready` retires HOLD; `req_ready` rises the following cycle.
- `resp_ready` is ignored outside HOLD.
- `req_*` inputs are sampled only in the acceptance cycle and may change freely afterwards.
- `ram_*` outputs are combinational from `req_*` and state; `resp_*` outputs are registered.

## Test plan
- **Word store/load:** store word 0x12345678 to 0x100 → `ram_wen`=1111, `ram_addr`=0x40, `resp_valid` at T+1. Then load word 0x100 → `resp_data`=0x12345678 at T+2, `resp_exc`=0.
- **Byte loads:** memory word 0x80FF7F01 at 0x200. Signed byte load at 0x203 → 0xFFFFFF80; unsigned → 0x00000080. Signed halfword load at 0x202 → 0xFFFF80FF.
- **Byte store:** byte store 0xAB to 0x301 → `ram_wen`=0010, `ram_wdata`=0xABABABAB. Word reload of 0x300 shows 0xAB only in bits 15:8.
- **Exceptions:** halfword load at 0x401 → `ram_en` never asserted; `resp_exc`=1, `resp_badaddr`=0x401, `resp_data`=0 at T+1. Size 11 at 0x400 behaves the same.
- **Backpressure:** hold `resp_ready`=0 for 3 cycles after a load response → `resp_valid` and `resp_data` stay constant and `req_ready`=0 throughout. `req_ready`=1 the cycle after `resp_ready` pulses.
- **Mid-load reset:** assert `resetn`=0 in WAIT → next cycle `resp_valid`=0, state IDLE. After release, the first new request is accepted normally.

Source files
------------

// File: rtl/dmem_access_ctrl_if.sv
// ============================================================================
// Module   : dmem_access_ctrl_if
// Purpose  : MEM-stage request/response and data-SRAM signal bundle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_access_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_sign;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;

    logic              ram_en;
    logic [3:0]        ram_wen;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_data;
    logic              resp_exc;
    logic [31:0]       resp_badaddr;

    // Controller side
    modport slave (
        input  req_valid, req_write, req_size, req_sign, req_addr, req_wdata,
        input  ram_rdata, resp_ready,
        output req_ready, ram_en, ram_wen, ram_addr, ram_wdata,
        output resp_valid, resp_data, resp_exc, resp_badaddr
    );

    // Pipeline and SRAM side
    modport master (
        output req_valid, req_write, req_size, req_sign, req_addr, req_wdata,
        output ram_rdata, resp_ready,
        input  req_ready, ram_en, ram_wen, ram_addr, ram_wdata,
        input  resp_valid, resp_data, resp_exc, resp_badaddr
    );
endinterface

`default_nettype wire

// File: rtl/dmem_access_ctrl.sv
// ============================================================================
// Module   : dmem_access_ctrl
// Purpose  : One-at-a-time load/store controller for a 1-cycle-latency data
//            SRAM with alignment checking and registered responses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_access_ctrl #(
    parameter int ADDR_W = 16
) (
    input  wire logic         clk,
    input  wire logic         resetn,
    dmem_access_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [1:0] c_SZ_BYTE = 2'b00;
    localparam logic [1:0] c_SZ_HALF = 2'b01;
    localparam logic [1:0] c_SZ_WORD = 2'b10;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [1:0]  r_off;
    logic [1:0]  r_size;
    logic        r_sign;

    logic        r_resp_valid;
    logic        r_resp_exc;
    logic [31:0] r_resp_data;
    logic [31:0] r_resp_badaddr;

    logic        w_req_ready;
    logic        w_accept;
    logic        w_misalign;
    logic        w_ram_en;
    logic        w_ram_write;
    logic [3:0]  w_wen;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;

    assign w_req_ready = (r_state == ST_IDLE) && resetn;
    assign w_accept    = bus.req_valid && w_req_ready;
    assign w_ram_en    = w_accept && !w_misalign;
    assign w_ram_write = w_ram_en && bus.req_write;

    always_comb begin
        w_misalign = 1'b0;
        case (bus.req_size)
            c_SZ_BYTE: w_misalign = 1'b0;
            c_SZ_HALF: w_misalign = bus.req_addr[0];
            c_SZ_WORD: w_misalign = |bus.req_addr[1:0];
            default:   w_misalign = 1'b1;
        endcase
    end

    // Store data is replicated across lanes so the write enables alone pick the bytes.
    always_comb begin
        w_wen   = 4'b0000;
        w_wdata = 32'd0;
        case (bus.req_size)
            c_SZ_BYTE: begin
                w_wen   = 4'b0001 << bus.req_addr[1:0];
                w_wdata = {4{bus.req_wdata[7:0]}};
            end
            c_SZ_HALF: begin
                w_wen   = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                w_wen   = 4'b1111;
                w_wdata = bus.req_wdata;
            end
        endcase
    end

    assign bus.req_ready = w_req_ready;
    assign bus.ram_en    = w_ram_en;
    assign bus.ram_wen   = w_ram_write ? w_wen : 4'b0000;
    assign bus.ram_addr  = w_ram_en ? bus.req_addr[ADDR_W+1:2] : '0;
    assign bus.ram_wdata = w_ram_write ? w_wdata : 32'd0;

    // Lane select and extension use the offset/size/sign latched at acceptance.
    always_comb begin
        w_byte = 8'd0;
        case (r_off)
            2'd0:    w_byte = bus.ram_rdata[7:0];
            2'd1:    w_byte = bus.ram_rdata[15:8];
            2'd2:    w_byte = bus.ram_rdata[23:16];
            default: w_byte = bus.ram_rdata[31:24];
        endcase
        w_half = r_off[1] ? bus.ram_rdata[31:16] : bus.ram_rdata[15:0];

        w_load_data = bus.ram_rdata;
        case (r_size)
            c_SZ_BYTE: w_load_data = {{24{r_sign & w_byte[7]}}, w_byte};
            c_SZ_HALF: w_load_data = {{16{r_sign & w_half[15]}}, w_half};
            default:   w_load_data = bus.ram_rdata;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (w_misalign || bus.req_write) ? ST_HOLD : ST_WAIT;
                end
            end
            ST_WAIT: w_state_nxt = ST_HOLD;
            ST_HOLD: begin
                if (bus.resp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_off          <= 2'd0;
            r_size         <= 2'd0;
            r_sign         <= 1'b0;
            r_resp_valid   <= 1'b0;
            r_resp_exc     <= 1'b0;
            r_resp_data    <= 32'd0;
            r_resp_badaddr <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_misalign) begin
                            r_resp_valid   <= 1'b1;
                            r_resp_exc     <= 1'b1;
                            r_resp_data    <= 32'd0;
                            r_resp_badaddr <= bus.req_addr;
                        end else if (bus.req_write) begin
                            r_resp_valid   <= 1'b1;
                            r_resp_exc     <= 1'b0;
                            r_resp_data    <= 32'd0;
                            r_resp_badaddr <= 32'd0;
                        end else begin
                            r_off  <= bus.req_addr[1:0];
                            r_size <= bus.req_size;
                            r_sign <= bus.req_sign;
                        end
                    end
                end
                ST_WAIT: begin
                    r_resp_valid   <= 1'b1;
                    r_resp_exc     <= 1'b0;
                    r_resp_data    <= w_load_data;
                    r_resp_badaddr <= 32'd0;
                end
                ST_HOLD: begin
                    if (bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_resp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.resp_valid   = r_resp_valid;
    assign bus.resp_exc     = r_resp_exc;
    assign bus.resp_data    = r_resp_data;
    assign bus.resp_badaddr = r_resp_badaddr;

endmodule

`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
// ============================================================================
// Module   : tb_dmem_access_ctrl
// Purpose  : Self-checking bench: directed vector table, corner sequences and
//            random traffic against a byte-addressed memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_access_ctrl;

    localparam int c_ADDR_W = 16;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    dmem_access_ctrl_if #(.ADDR_W(c_ADDR_W)) bus ();

    dmem_access_ctrl #(.ADDR_W(c_ADDR_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // SRAM model: one-cycle read latency, garbage on rdata when not reading
    logic [31:0] sram [0:65535];
    logic [7:0]  ref_mem [int unsigned];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] wen);
        logic [31:0] r;
        r = old;
        for (int l = 0; l < 4; l++) if (wen[l]) r[8*l +: 8] = wd[8*l +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (bus.ram_en && bus.ram_wen == 4'b0000) begin
            bus.ram_rdata <= sram[bus.ram_addr];
        end else begin
            bus.ram_rdata <= $urandom;
        end
        if (bus.ram_en && bus.ram_wen != 4'b0000) begin
            sram[bus.ram_addr] <= merge(sram[bus.ram_addr], bus.ram_wdata, bus.ram_wen);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        en;
        logic [3:0]  wen;
        logic [15:0] raddr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] data;
        logic        exc;
        logic [31:0] bad;
    } obs_t;

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] a;
        logic [31:0] wd;
        logic        en;
        logic [3:0]  wen;
        logic [15:0] raddr;
        logic [31:0] wdata;
        logic        chk_wdata;
        int          lat;
        logic [31:0] data;
        logic        exc;
        logic [31:0] bad;
    } vec_t;

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    // Reference: bytes in a flat memory; alignment means address divisible by access size
    function automatic void model(input logic w, input logic [1:0] sz, input logic sg,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic exc, output logic [3:0] wen,
                                  output logic [31:0] data, output int lat);
        int unsigned n;
        n    = 1 << sz;
        exc  = (sz == 2'd3) || ((a % n) != 0);
        wen  = 4'b0000;
        data = 32'd0;
        lat  = 1;
        if (!exc && w) begin
            for (int i = 0; i < int'(n); i++) begin
                ref_mem[a + i] = wd[8*i +: 8];
                wen[(a % 4) + i] = 1'b1;
            end
        end else if (!exc) begin
            lat = 2;
            for (int i = 0; i < int'(n); i++) data = data | (32'(ref_byte(a + i)) << (8*i));
            if (sg && n < 4 && data[8*n-1]) data = data | ~((32'd1 << (8*n)) - 32'd1);
        end
    endfunction

    // Entered and left at a falling edge; hold = cycles resp_ready stays low in HOLD
    task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd, input int hold,
                           output obs_t o);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_size  = sz;
        bus.req_sign  = sg;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        #1;
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        o.en    = bus.ram_en;
        o.wen   = bus.ram_wen;
        o.raddr = bus.ram_addr;
        o.wdata = bus.ram_wdata;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_write = 1'($urandom);
        bus.req_size  = 2'($urandom);
        bus.req_sign  = 1'($urandom);
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        #1;
        chk("ram_en_after_accept", 32'(bus.ram_en), 32'd0);
        o.lat = 1;
        while (!bus.resp_valid && o.lat < 6) begin
            @(negedge clk);
            o.lat++;
        end
        chk("resp_valid_seen", 32'(bus.resp_valid), 32'd1);
        o.data = bus.resp_data;
        o.exc  = bus.resp_exc;
        o.bad  = bus.resp_badaddr;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 32'(bus.resp_valid), 32'd1);
            chk("hold_data", bus.resp_data, o.data);
            chk("hold_exc_bad", {bus.resp_badaddr[30:0], bus.resp_exc}, {o.bad[30:0], o.exc});
            chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        chk("retire_valid", 32'(bus.resp_valid), 32'd0);
        chk("retire_req_ready", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic check_vs_model(input logic w, input logic [1:0] sz, input logic sg,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  input obs_t o);
        logic        e_exc;
        logic [3:0]  e_wen;
        logic [31:0] e_data;
        int          e_lat;
        int          off;
        model(w, sz, sg, a, wd, e_exc, e_wen, e_data, e_lat);
        off = int'(a[1:0]);
        chk("m_exc", 32'(o.exc), 32'(e_exc));
        chk("m_en", 32'(o.en), 32'(!e_exc));
        chk("m_lat", o.lat, e_lat);
        chk("m_data", o.data, e_data);
        chk("m_bad", o.bad, e_exc ? a : 32'd0);
        chk("m_wen", 32'(o.wen), 32'(e_wen));
        if (!e_exc) chk("m_raddr", 32'(o.raddr), (a >> 2) & 32'hFFFF);
        for (int l = 0; l < 4; l++) begin
            if (e_wen[l]) chk("m_wdata_lane", 32'(o.wdata[8*l +: 8]), 32'(wd[8*(l-off) +: 8]));
        end
    endtask

    vec_t vt[$];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        obs_t o;
        logic        dx;
        logic [3:0]  dw;
        logic [31:0] dd;
        int          dl;

        for (int i = 0; i < 65536; i++) sram[i] = 32'd0;

        //        w     sz    sg    addr       wdata         en    wen   raddr   wdata         cw    lat data          exc   bad
        vt.push_back('{1'b1, 2'd2, 1'b0, 32'h100, 32'h12345678, 1'b1, 4'hF, 16'h40, 32'h12345678, 1'b1, 1, 32'h0,        1'b0, 32'h0});
        vt.push_back('{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        1'b1, 4'h0, 16'h40, 32'h0,        1'b0, 2, 32'h12345678, 1'b0, 32'h0});
        vt.push_back('{1'b1, 2'd2, 1'b0, 32'h200, 32'h80FF7F01, 1'b1, 4'hF, 16'h80, 32'h80FF7F01, 1'b1, 1, 32'h0,        1'b0, 32'h0});
        vt.push_back('{1'b0, 2'd0, 1'b1, 32'h203, 32'h0,        1'b1, 4'h0, 16'h80, 32'h0,        1'b0, 2, 32'hFFFFFF80, 1'b0, 32'h0});
        vt.push_back('{1'b0, 2'd0, 1'b0, 32'h203, 32'h0,        1'b1, 4'h0, 16'h80, 32'h0,        1'b0, 2, 32'h00000080, 1'b0, 32'h0});
        vt.push_back('{1'b0, 2'd1, 1'b1, 32'h202, 32'h0,        1'b1, 4'h0, 16'h80, 32'h0,        1'b0, 2, 32'hFFFF80FF, 1'b0, 32'h0});
        vt.push_back('{1'b0, 2'd0, 1'b1, 32'h201, 32'h0,        1'b1, 4'h0, 16'h80, 32'h0,        1'b0, 2, 32'h0000007F, 1'b0, 32'h0});
        vt.push_back('{1'b0, 2'd1, 1'b1, 32'h200, 32'h0,        1'b1, 4'h0, 16'h80, 32'h0,        1'b0, 2, 32'h00007F01, 1'b0, 32'h0});
        vt.push_back('{1'b1, 2'd2, 1'b0, 32'h300, 32'h0,        1'b1, 4'hF, 16'hC0, 32'h0,        1'b1, 1, 32'h0,        1'b0, 32'h0});
        vt.push_back('{1'b1, 2'd0, 1'b0, 32'h301, 32'h123456AB, 1'b1, 4'h2, 16'hC0, 32'hABABABAB, 1'b1, 1, 32'h0,        1'b0, 32'h0});
        vt.push_back('{1'b0, 2'd2, 1'b0, 32'h300, 32'h0,        1'b1, 4'h0, 16'hC0, 32'h0,        1'b0, 2, 32'h0000AB00, 1'b0, 32'h0});
        vt.push_back('{1'b0, 2'd1, 1'b0, 32'h401, 32'h0,        1'b0, 4'h0, 16'h0,  32'h0,        1'b0, 1, 32'h0,        1'b1, 32'h401});
        vt.push_back('{1'b0, 2'd3, 1'b0, 32'h400, 32'h0,        1'b0, 4'h0, 16'h0,  32'h0,        1'b0, 1, 32'h0,        1'b1, 32'h400});
        vt.push_back('{1'b1, 2'd2, 1'b0, 32'h302, 32'hDEADBEEF, 1'b0, 4'h0, 16'h0,  32'h0,        1'b0, 1, 32'h0,        1'b1, 32'h302});
        vt.push_back('{1'b1, 2'd1, 1'b0, 32'h302, 32'h0000BEEF, 1'b1, 4'hC, 16'hC0, 32'hBEEFBEEF, 1'b1, 1, 32'h0,        1'b0, 32'h0});
        vt.push_back('{1'b0, 2'd2, 1'b0, 32'h300, 32'h0,        1'b1, 4'h0, 16'hC0, 32'h0,        1'b0, 2, 32'hBEEFAB00, 1'b0, 32'h0});
        vt.push_back('{1'b1, 2'd0, 1'b0, 32'h303, 32'h0000005A, 1'b1, 4'h8, 16'hC0, 32'h5A5A5A5A, 1'b1, 1, 32'h0,        1'b0, 32'h0});
        vt.push_back('{1'b0, 2'd2, 1'b0, 32'h300, 32'h0,        1'b1, 4'h0, 16'hC0, 32'h0,        1'b0, 2, 32'h5AEFAB00, 1'b0, 32'h0});
        vt.push_back('{1'b0, 2'd0, 1'b1, 32'h302, 32'h0,        1'b1, 4'h0, 16'hC0, 32'h0,        1'b0, 2, 32'hFFFFFFEF, 1'b0, 32'h0});

        // Reset: a pending request must not be seen while resetn is low
        resetn         = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_size   = 2'd2;
        bus.req_sign   = 1'b0;
        bus.req_addr   = 32'h10;
        bus.req_wdata  = 32'hFFFFFFFF;
        bus.resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_ram_en", 32'(bus.ram_en), 32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_exc", 32'(bus.resp_exc), 32'd0);
        chk("rst_resp_data", bus.resp_data, 32'd0);
        chk("rst_resp_badaddr", bus.resp_badaddr, 32'd0);
        bus.req_valid = 1'b0;
        resetn        = 1'b1;
        #1;
        chk("rel_req_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        chk("idle_ram_en", 32'(bus.ram_en), 32'd0);

        foreach (vt[i]) begin
            run_req(vt[i].w, vt[i].sz, vt[i].sg, vt[i].a, vt[i].wd, 0, o);
            model(vt[i].w, vt[i].sz, vt[i].sg, vt[i].a, vt[i].wd, dx, dw, dd, dl);
            chk($sformatf("v%0d_en", i), 32'(o.en), 32'(vt[i].en));
            chk($sformatf("v%0d_wen", i), 32'(o.wen), 32'(vt[i].wen));
            if (vt[i].en) chk($sformatf("v%0d_raddr", i), 32'(o.raddr), 32'(vt[i].raddr));
            if (vt[i].chk_wdata) chk($sformatf("v%0d_wdata", i), o.wdata, vt[i].wdata);
            chk($sformatf("v%0d_lat", i), o.lat, vt[i].lat);
            chk($sformatf("v%0d_data", i), o.data, vt[i].data);
            chk($sformatf("v%0d_exc", i), 32'(o.exc), 32'(vt[i].exc));
            chk($sformatf("v%0d_bad", i), o.bad, vt[i].bad);
        end

        // Backpressure: response held for three cycles before resp_ready
        run_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 3, o);
        chk("bp_data", o.data, 32'h12345678);
        chk("bp_lat", o.lat, 2);

        // Reset during WAIT abandons the load
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_size  = 2'd2;
        bus.req_sign  = 1'b0;
        bus.req_addr  = 32'h200;
        #1;
        chk("mr_ram_en", 32'(bus.ram_en), 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        resetn        = 1'b0;
        @(negedge clk);
        chk("mr_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("mr_req_ready_low", 32'(bus.req_ready), 32'd0);
        chk("mr_ram_en_low", 32'(bus.ram_en), 32'd0);
        resetn = 1'b1;
        #1;
        chk("mr_idle_after", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        chk("mr_no_resp", 32'(bus.resp_valid), 32'd0);
        run_req(1'b1, 2'd1, 1'b0, 32'h206, 32'h0000C3A5, 0, o);
        check_vs_model(1'b1, 2'd1, 1'b0, 32'h206, 32'h0000C3A5, o);
        run_req(1'b0, 2'd1, 1'b1, 32'h206, 32'h0, 0, o);
        check_vs_model(1'b0, 2'd1, 1'b1, 32'h206, 32'h0, o);

        // Random traffic against the byte model
        for (int k = 0; k < 200; k++) begin
            logic        w;
            logic [1:0]  sz;
            logic        sg;
            logic [31:0] a;
            logic [31:0] wd;
            w  = 1'($urandom);
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom);
            a  = (32'($urandom_range(0, 3)) << 12) | 32'($urandom_range(0, 31));
            wd = $urandom;
            run_req(w, sz, sg, a, wd, $urandom_range(0, 2), o);
            check_vs_model(w, sz, sg, a, wd, o);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
